// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: the loader state enum and the
// word / address geometry used by the loader and anything that talks to it.
// No ports (package).
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage : prog_loader_pkg

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Copies a flat program image into memory one 16-bit word per write.
// Word 0 of the image is the origin: it becomes pc_init and the first write
// address. Words 1..N-1 are written to consecutive addresses from the origin.
// A write whose address is 16'hFFFF while words remain ends the load with err.
//
// Parameters:
//   SIZE       image width in bits (multiple of 16, >= 16)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a load (honoured in IDLE and DONE only)
//   prog       flat image, word k = prog[16k+15:16k]
//   mem_addr   write address        mem_wdata  write data
//   mem_we     write request        mem_ack    write accepted this edge
//   pc_init    latched origin       busy       load in progress
//   done       load complete (level) err      load aborted on address wrap
//   checksum   (only with PROG_LOADER_CHECKSUM_EN) mod-2^16 sum of acked data
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the checksum output.
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int SIZE = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   prog,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_init,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] checksum
`endif
);

    localparam int NWORDS = SIZE / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    ld_state_e         state_q, state_d;
    logic [SIZE-1:0]   snap_q,  snap_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic              err_q,   err_d;
    logic [WORD_W-1:0] wr_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q,   sum_d;
`endif

    // Current word to write, taken straight out of the snapshot.
    assign wr_word = snap_q[WORD_W*idx_q +: WORD_W];

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        err_d   = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    snap_d  = prog;
                    err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                pc_d    = snap_q[ADDR_W-1:0];
                addr_d  = snap_q[ADDR_W-1:0];
                idx_d   = IDX_W'(1);
                // An origin-only image has nothing to write.
                state_d = (NWORDS == 1) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    addr_d = addr_q + ADDR_W'(1);
                    idx_d  = idx_q + IDX_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + wr_word;
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else if (addr_q == ADDR_MAX) begin
                        // Words remain but the address space is exhausted:
                        // stop rather than wrap to 0x0000.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Status and memory outputs decode the state directly, so an asserted
    // reset clears them without waiting for a clock edge.
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = mem_we ? addr_q  : '0;
    assign mem_wdata = mem_we ? wr_word : '0;
    assign busy      = (state_q == ST_LATCH) || (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign pc_init   = pc_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign checksum  = sum_q;
`endif

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. A SIZE=80 instance covers the main load
// behaviour (table vectors, reset mid-load, randomized loads against a
// reference model); a SIZE=16 instance covers the origin-only image.
// Cycle numbers count the edge that samples start as cycle 1.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [79:0] prog;
    logic [15:0] mem_addr, mem_wdata, pc_init;
    logic        mem_we, mem_ack, busy, done, err;

    logic        start16;
    logic [15:0] prog16;
    logic [15:0] mem_addr16, mem_wdata16, pc_init16;
    logic        mem_we16, mem_ack16, busy16, done16, err16;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [15:0] checksum, checksum16;
`endif

    prog_loader #(.SIZE(80)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog(prog),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack), .pc_init(pc_init), .busy(busy), .done(done),
        .err(err)
`ifdef PROG_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    prog_loader #(.SIZE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .prog(prog16),
        .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_we(mem_we16),
        .mem_ack(mem_ack16), .pc_init(pc_init16), .busy(busy16), .done(done16),
        .err(err16)
`ifdef PROG_LOADER_CHECKSUM_EN
        , .checksum(checksum16)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cap_addr[$];
    logic [15:0] cap_data[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    bit          exp_err;

    typedef struct {
        logic [79:0] img;
        int          dly;
        int          exp_nwr;
        logic        exp_err;
        int          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: word k (k>=1) goes to origin+k-1; an address beyond 0xFFFF
    // means the image did not fit, which ends the load with an error.
    function automatic void model(input logic [79:0] img);
        int origin;
        int a;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        origin = int'(img[15:0]);
        for (int k = 1; k < 5; k++) begin
            a = origin + k - 1;
            if (a > 65535) begin
                exp_err = 1'b1;
                break;
            end
            exp_addr.push_back(16'(a));
            exp_data.push_back(img[16*k +: 16]);
        end
    endfunction

    // dly >= 0: ack after dly idle cycles of each write; dly < 0: random ack
    // every cycle (also while no write is pending).
    task automatic do_load(input string tag, input logic [79:0] img, input int dly,
                           input bit noise, output int done_cyc, output int first_we);
        logic [15:0] pa, pd;
        bit          pend;
        bit          ack;
        int          wc;
        cap_addr.delete();
        cap_data.delete();
        done_cyc = -1;
        first_we = -1;
        pend = 1'b0;
        wc = 0;
        pa = '0;
        pd = '0;
        @(negedge clk);
        prog = img;
        start = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            prog = {$urandom(), $urandom(), 16'($urandom())};
            if (cyc == 1) begin
                check({tag, " busy@1"}, 32'(busy), 32'(1));
                check({tag, " done@1"}, 32'(done), 32'(0));
                check({tag, " err@1"},  32'(err),  32'(0));
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            ack = 1'b0;
            if (mem_we) begin
                if (first_we < 0) first_we = cyc;
                if (pend) begin
                    check({tag, " hold_addr"}, 32'(mem_addr),  32'(pa));
                    check({tag, " hold_data"}, 32'(mem_wdata), 32'(pd));
                end
                if (dly < 0) ack = ($urandom_range(0, 1) == 1);
                else         ack = (wc >= dly);
                wc++;
                if (ack) begin
                    cap_addr.push_back(mem_addr);
                    cap_data.push_back(mem_wdata);
                    wc = 0;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pa = mem_addr;
                    pd = mem_wdata;
                end
            end else begin
                pend = 1'b0;
                if (dly < 0) ack = ($urandom_range(0, 2) == 0);
            end
            mem_ack = ack;
            if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
        end
        check({tag, " done_seen"}, 32'(done), 32'(1));
        mem_ack = 1'b0;
        start = 1'b0;
    endtask

    task automatic compare_load(input string tag, input logic [79:0] img);
        int unsigned sum;
        model(img);
        check({tag, " nwr"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
        sum = 0;
        for (int i = 0; i < exp_addr.size(); i++) begin
            sum += int'(exp_data[i]);
            if (i < cap_addr.size()) begin
                check($sformatf("%s addr%0d", tag, i), 32'(cap_addr[i]), 32'(exp_addr[i]));
                check($sformatf("%s data%0d", tag, i), 32'(cap_data[i]), 32'(exp_data[i]));
            end
        end
        check({tag, " err"},     32'(err),     32'(exp_err));
        check({tag, " pc_init"}, 32'(pc_init), 32'(img[15:0]));
        check({tag, " busy"},    32'(busy),    32'(0));
        check({tag, " mem_we"},  32'(mem_we),  32'(0));
`ifdef PROG_LOADER_CHECKSUM_EN
        check({tag, " checksum"}, 32'(checksum), 32'(sum[15:0]));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [79:0] img;
        logic [15:0] origin;
        int          dc, fw, dly;
        bit          saw_we;

        vecs[0] = '{80'h0FFF_1704_16E8_1261_3000, 0, 4, 1'b0, 6};
        vecs[1] = '{80'h0FFF_1704_16E8_1261_3000, 3, 4, 1'b0, 18};
        vecs[2] = '{80'h0FFF_1704_16E8_1261_FFFE, 0, 2, 1'b1, 4};
        vecs[3] = '{80'hAAAA_BBBB_CCCC_DDDD_FFFF, 0, 1, 1'b1, 3};
        vecs[4] = '{80'h4444_3333_2222_1111_FFFC, 0, 4, 1'b0, 6};

        rst_n = 1'b0;
        start = 1'b0;   prog = '0;   mem_ack = 1'b0;
        start16 = 1'b0; prog16 = '0; mem_ack16 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst mem_we",    32'(mem_we),    32'(0));
        check("rst busy",      32'(busy),      32'(0));
        check("rst done",      32'(done),      32'(0));
        check("rst err",       32'(err),       32'(0));
        check("rst mem_addr",  32'(mem_addr),  32'(0));
        check("rst mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst pc_init",   32'(pc_init),   32'(0));
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_load(tag, vecs[i].img, vecs[i].dly, 1'b0, dc, fw);
            compare_load(tag, vecs[i].img);
            check({tag, " tbl_nwr"},   32'(cap_addr.size()), 32'(vecs[i].exp_nwr));
            check({tag, " tbl_err"},   32'(err),             32'(vecs[i].exp_err));
            check({tag, " done_cyc"},  32'(dc),              32'(vecs[i].exp_done));
            check({tag, " first_we"},  32'(fw),              32'(2));
            $display("vec%0d origin=%h writes=%0d err=%0b done_cycle=%0d",
                     i, vecs[i].img[15:0], cap_addr.size(), err, dc);
        end

        // Reset after the second ack of a load
        @(negedge clk);
        prog = vecs[0].img;
        start = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst pre_addr", 32'(mem_addr), 32'(16'h3002));
        #2 rst_n = 1'b0;
        #1;
        check("midrst mem_we",    32'(mem_we),    32'(0));
        check("midrst busy",      32'(busy),      32'(0));
        check("midrst done",      32'(done),      32'(0));
        check("midrst err",       32'(err),       32'(0));
        check("midrst mem_addr",  32'(mem_addr),  32'(0));
        check("midrst mem_wdata", 32'(mem_wdata), 32'(0));
        check("midrst pc_init",   32'(pc_init),   32'(0));
        repeat (2) begin
            @(negedge clk);
            check("midrst held_we", 32'(mem_we), 32'(0));
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("postrst we", 32'(mem_we), 32'(0));
            check("postrst busy", 32'(busy), 32'(0));
        end
        mem_ack = 1'b0;
        $display("midrst load abandoned, reloading");
        do_load("reload", vecs[0].img, 0, 1'b0, dc, fw);
        compare_load("reload", vecs[0].img);
        $display("reload writes=%0d first_addr=%h", cap_addr.size(),
                 (cap_addr.size() > 0) ? cap_addr[0] : 16'h0);

        // Randomized loads against the model
        for (int r = 0; r < 25; r++) begin
            string tag;
            tag = $sformatf("rnd%0d", r);
            if ($urandom_range(0, 2) == 0) origin = 16'hFFFF - 16'($urandom_range(0, 4));
            else                           origin = 16'($urandom());
            img = {$urandom(), $urandom(), origin};
            dly = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2));
            do_load(tag, img, dly, 1'b1, dc, fw);
            compare_load(tag, img);
            $display("rnd%0d origin=%h dly=%0d writes=%0d err=%0b", r, origin, dly,
                     cap_addr.size(), err);
        end

        // Origin-only image
        saw_we = 1'b0;
        dc = -1;
        @(negedge clk);
        prog16 = 16'h4000;
        start16 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 20; cyc++) begin
            @(negedge clk);
            start16 = 1'b0;
            prog16 = 16'($urandom());
            if (mem_we16) saw_we = 1'b1;
            if (done16) begin
                dc = cyc;
                break;
            end
        end
        check("s16 done_cyc", 32'(dc),        32'(2));
        check("s16 no_write", 32'(saw_we),    32'(0));
        check("s16 pc_init",  32'(pc_init16), 32'(16'h4000));
        check("s16 err",      32'(err16),     32'(0));
        check("s16 busy",     32'(busy16),    32'(0));
        $display("size16 origin=4000 done_cycle=%0d pc_init=%h", dc, pc_init16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prog_loader
